// File: rtl/goto_rep_monitor.sv
// In-fabric monitor for "after start rises, evt high on exactly REPS cycles while
// guard holds, then end arrives"; emits registered pass/fail pulses and statistics.
module goto_rep_monitor #(
  parameter int unsigned REPS    = 3,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned STAT_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic                        evt_i,
  input  logic                        guard_i,
  input  logic                        end_i,
  output logic                        busy_o,
  output logic                        pass_o,
  output logic                        fail_o,
  output logic [1:0]                  fail_code_o,
  output logic [$clog2(REPS+1)-1:0]   evt_cnt_o,
  output logic [STAT_W-1:0]           pass_cnt_o,
  output logic [STAT_W-1:0]           fail_cnt_o
);

  localparam int unsigned CNT_W = $clog2(REPS + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COUNT    = 2'd1;
  localparam logic [1:0] ST_WAIT_END = 2'd2;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_GUARD   = 2'b01;
  localparam logic [1:0] CODE_OVER    = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [1:0]        code_q, code_d;
  logic [STAT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [STAT_W-1:0] fail_cnt_q, fail_cnt_d;

  logic              rise;
  logic              active;
  logic              counting;
  logic [TMR_W-1:0]  win_idx;
  logic [CNT_W-1:0]  cnt_base;
  logic [CNT_W-1:0]  cnt_inc;
  logic              dec_guard, dec_pass, dec_over, dec_tmo;

  // The rise cycle is window cycle 0 and is judged while still in IDLE, so the
  // per-window index and count are taken from zero rather than the stale flops.
  always_comb begin
    rise     = start_i & ~start_q;
    active   = (state_q != ST_IDLE) | rise;
    counting = (state_q == ST_IDLE) | (state_q == ST_COUNT);
    win_idx  = (state_q == ST_IDLE) ? '0 : tmr_q;
    cnt_base = (state_q == ST_IDLE) ? '0 : cnt_q;
    cnt_inc  = counting ? (cnt_base + CNT_W'(evt_i)) : cnt_base;

    dec_guard = active & ~guard_i;
    dec_pass  = active & (state_q == ST_WAIT_END) & end_i;
    dec_over  = active & (state_q == ST_WAIT_END) & ~end_i & evt_i;
    dec_tmo   = active & (win_idx == TMR_W'(TIMEOUT - 1));
  end

  always_comb begin
    state_d    = state_q;
    start_d    = start_i;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    code_d     = code_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;

    if (active) begin
      cnt_d = cnt_inc;
      if (dec_guard || dec_pass || dec_over || dec_tmo) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
        if (dec_guard) begin
          fail_d = 1'b1;
          code_d = CODE_GUARD;
        end else if (dec_pass) begin
          pass_d = 1'b1;
          code_d = CODE_NONE;
        end else if (dec_over) begin
          fail_d = 1'b1;
          code_d = CODE_OVER;
        end else begin
          fail_d = 1'b1;
          code_d = CODE_TIMEOUT;
        end
        if (pass_d && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + 1'b1;
        if (fail_d && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + 1'b1;
      end else begin
        tmr_d = win_idx + 1'b1;
        case (state_q)
          ST_IDLE, ST_COUNT:
            state_d = (cnt_inc == CNT_W'(REPS)) ? ST_WAIT_END : ST_COUNT;
          ST_WAIT_END:
            state_d = ST_WAIT_END;
          default:
            state_d = ST_IDLE;
        endcase
      end
    end else if ((state_q != ST_IDLE) && (state_q != ST_COUNT) && (state_q != ST_WAIT_END)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      code_q     <= CODE_NONE;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      code_q     <= code_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_code_o = code_q;
  assign evt_cnt_o   = cnt_q;
  assign pass_cnt_o  = pass_cnt_q;
  assign fail_cnt_o  = fail_cnt_q;

endmodule

// File: tb/tb_goto_rep_monitor.sv
// Directed bench for goto_rep_monitor (REPS=3, TIMEOUT=64, end_i tied to start_i).
module tb_goto_rep_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic       evt_i = 1'b0;
  logic       guard_i = 1'b1;
  logic       busy_o, pass_o, fail_o;
  logic [1:0] fail_code_o;
  logic [1:0] evt_cnt_o;
  logic [7:0] pass_cnt_o, fail_cnt_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  goto_rep_monitor #(.REPS(3), .TIMEOUT(64), .STAT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .evt_i      (evt_i),
    .guard_i    (guard_i),
    .end_i      (start_i),
    .busy_o     (busy_o),
    .pass_o     (pass_o),
    .fail_o     (fail_o),
    .fail_code_o(fail_code_o),
    .evt_cnt_o  (evt_cnt_o),
    .pass_cnt_o (pass_cnt_o),
    .fail_cnt_o (fail_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tid;
    int         cyc;
    logic       first;
    logic       start, evt, guard;
    logic       busy, pass, fail;
    logic [1:0] code;
    logic [1:0] cnt;
    logic [7:0] pcnt, fcnt;
  } vec_t;

  vec_t tbl[$];
  int   cyc_ctr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    start_i = 1'b0;
    evt_i   = 1'b0;
    guard_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input int tid, input logic first, input logic s, input logic e, input logic g,
                     input logic b, input logic p, input logic f, input logic [1:0] code,
                     input logic [1:0] cnt, input logic [7:0] pc, input logic [7:0] fc);
    vec_t v;
    if (first) cyc_ctr = 0;
    v.tid = tid; v.cyc = cyc_ctr; v.first = first;
    v.start = s; v.evt = e; v.guard = g;
    v.busy = b; v.pass = p; v.fail = f; v.code = code; v.cnt = cnt;
    v.pcnt = pc; v.fcnt = fc;
    tbl.push_back(v);
    cyc_ctr++;
  endtask

  task automatic check_all(input string tag, input logic b, input logic p, input logic f,
                           input logic [1:0] code, input logic [1:0] cnt,
                           input logic [7:0] pc, input logic [7:0] fc);
    chk({tag, " busy"}, 32'(busy_o), 32'(b));
    chk({tag, " pass"}, 32'(pass_o), 32'(p));
    chk({tag, " fail"}, 32'(fail_o), 32'(f));
    chk({tag, " code"}, 32'(fail_code_o), 32'(code));
    chk({tag, " evt_cnt"}, 32'(evt_cnt_o), 32'(cnt));
    chk({tag, " pass_cnt"}, 32'(pass_cnt_o), 32'(pc));
    chk({tag, " fail_cnt"}, 32'(fail_cnt_o), 32'(fc));
  endtask

  initial begin : main
    int first_fail;
    int pulses;
    logic [1:0] code_seen;

    // Test 1: rise @2, evt @3,5,8, end @10 -> pass @11; rise on decision cycle ignored
    add(1,1, 0,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(1,0, 0,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(1,0, 1,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(1,0, 0,1,1, 1,0,0,2'd0,2'd0,8'd0,8'd0);
    add(1,0, 0,0,1, 1,0,0,2'd0,2'd1,8'd0,8'd0);
    add(1,0, 0,1,1, 1,0,0,2'd0,2'd1,8'd0,8'd0);
    add(1,0, 0,0,1, 1,0,0,2'd0,2'd2,8'd0,8'd0);
    add(1,0, 0,0,1, 1,0,0,2'd0,2'd2,8'd0,8'd0);
    add(1,0, 0,1,1, 1,0,0,2'd0,2'd2,8'd0,8'd0);
    add(1,0, 0,0,1, 1,0,0,2'd0,2'd3,8'd0,8'd0);
    add(1,0, 1,0,1, 1,0,0,2'd0,2'd3,8'd0,8'd0);
    add(1,0, 0,0,1, 0,1,0,2'd0,2'd3,8'd1,8'd0);
    add(1,0, 0,0,1, 0,0,0,2'd0,2'd3,8'd1,8'd0);
    // Test 2: 4th evt @9 -> OVER fail @10; rise @10 (pulse cycle) opens a new window
    add(2,1, 0,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(2,0, 0,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(2,0, 1,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(2,0, 0,1,1, 1,0,0,2'd0,2'd0,8'd0,8'd0);
    add(2,0, 0,0,1, 1,0,0,2'd0,2'd1,8'd0,8'd0);
    add(2,0, 0,1,1, 1,0,0,2'd0,2'd1,8'd0,8'd0);
    add(2,0, 0,0,1, 1,0,0,2'd0,2'd2,8'd0,8'd0);
    add(2,0, 0,0,1, 1,0,0,2'd0,2'd2,8'd0,8'd0);
    add(2,0, 0,1,1, 1,0,0,2'd0,2'd2,8'd0,8'd0);
    add(2,0, 0,1,1, 1,0,0,2'd0,2'd3,8'd0,8'd0);
    add(2,0, 1,0,1, 0,0,1,2'd2,2'd3,8'd0,8'd1);
    add(2,0, 0,0,1, 1,0,0,2'd2,2'd0,8'd0,8'd1);
    add(2,0, 0,0,1, 1,0,0,2'd2,2'd0,8'd0,8'd1);
    // Test 3: guard low @6 -> GUARD fail @7; rise @7 opens a new window, evt @8 counts
    add(3,1, 0,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(3,0, 0,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(3,0, 1,0,1, 0,0,0,2'd0,2'd0,8'd0,8'd0);
    add(3,0, 0,1,1, 1,0,0,2'd0,2'd0,8'd0,8'd0);
    add(3,0, 0,0,1, 1,0,0,2'd0,2'd1,8'd0,8'd0);
    add(3,0, 0,1,1, 1,0,0,2'd0,2'd1,8'd0,8'd0);
    add(3,0, 0,0,0, 1,0,0,2'd0,2'd2,8'd0,8'd0);
    add(3,0, 1,0,1, 0,0,1,2'd1,2'd2,8'd0,8'd1);
    add(3,0, 0,1,1, 1,0,0,2'd1,2'd0,8'd0,8'd1);
    add(3,0, 0,0,1, 1,0,0,2'd1,2'd1,8'd0,8'd1);

    foreach (tbl[i]) begin
      if (tbl[i].first) do_reset();
      else tick();
      start_i = tbl[i].start;
      evt_i   = tbl[i].evt;
      guard_i = tbl[i].guard;
      check_all($sformatf("t%0d c%0d", tbl[i].tid, tbl[i].cyc), tbl[i].busy, tbl[i].pass,
                tbl[i].fail, tbl[i].code, tbl[i].cnt, tbl[i].pcnt, tbl[i].fcnt);
    end

    // Test 4: rise @2, evt @3,4, then silence; stray rise @20 -> TIMEOUT fail @66
    do_reset();
    tick();
    tick(); start_i = 1'b1;
    tick(); start_i = 1'b0; evt_i = 1'b1;
    tick();
    first_fail = -1;
    pulses     = 0;
    code_seen  = 2'd0;
    for (int c = 5; c <= 75; c++) begin
      tick();
      evt_i   = 1'b0;
      start_i = (c == 20);
      if (c == 21) chk("t4 busy after stray rise", 32'(busy_o), 32'd1);
      if (fail_o) begin
        pulses++;
        if (first_fail < 0) begin
          first_fail = c;
          code_seen  = fail_code_o;
        end
      end
    end
    chk("t4 timeout cycle", 32'(first_fail), 32'd66);
    chk("t4 pulse count", 32'(pulses), 32'd1);
    chk("t4 code", 32'(code_seen), 32'd3);
    chk("t4 evt_cnt", 32'(evt_cnt_o), 32'd2);
    chk("t4 busy idle", 32'(busy_o), 32'd0);

    // Test 5: evt @2,3,4 with rise @2, end @5 -> pass @6; then 300 guard fails saturate
    do_reset();
    tick();
    tick(); start_i = 1'b1; evt_i = 1'b1;
    tick(); start_i = 1'b0;
    tick();
    tick(); start_i = 1'b1; evt_i = 1'b0;
    chk("t5 busy wait_end", 32'(busy_o), 32'd1);
    tick(); start_i = 1'b0;
    chk("t5 pass", 32'(pass_o), 32'd1);
    chk("t5 evt_cnt", 32'(evt_cnt_o), 32'd3);
    chk("t5 pass_cnt", 32'(pass_cnt_o), 32'd1);
    for (int n = 0; n < 300; n++) begin
      tick(); start_i = 1'b1; guard_i = 1'b0;
      tick(); start_i = 1'b0; guard_i = 1'b1;
    end
    tick();
    chk("t5 fail_cnt saturated", 32'(fail_cnt_o), 32'd255);
    chk("t5 fail_code", 32'(fail_code_o), 32'd1);
    chk("t5 pass_cnt kept", 32'(pass_cnt_o), 32'd1);

    // Test 6: reset mid-window clears everything at once; release with start high opens a window
    tick(); start_i = 1'b1;
    tick(); start_i = 1'b0;
    tick();
    tick();
    chk("t6 busy before reset", 32'(busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all("t6 in reset", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 8'd0);
    start_i = 1'b1;
    pulses = 0;
    repeat (3) begin
      tick();
      if (pass_o || fail_o) pulses++;
    end
    chk("t6 no pulse in reset", 32'(pulses), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6 busy after release", 32'(busy_o), 32'd1);
    chk("t6 no pulse after release", 32'(pass_o | fail_o), 32'd0);
    tick();
    chk("t6 busy held", 32'(busy_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
